mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/mem_timer.sv | 25 ++
 rtl/mem_access.sv | 124 ++++++++++++
 tb/tb_mem_access.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: opcode constants, FSM state type and
// the memory-op decode helper used by both EX and MEM.
package mem_access_pkg;

  localparam logic [5:0] OP_LW = 6'b001000;
  localparam logic [5:0] OP_SW = 6'b001010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Wait-cycle counter for the MEM stage; expired is high once the count has
// reached MAX-1 so the owning FSM can give up on the bus in that cycle.
module mem_timer #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(MAX - 1));

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through in one cycle, runs LW/SW over
// a req/ack bus with a bounded wait, and registers the MEM/WB outputs.
module mem_access #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        misalign_err,
  output logic        bus_err
);
  import mem_access_pkg::*;

  // Bus handshake: mem_req is held high for the whole WAIT state with
  // address/data/we stable; the cycle in which mem_ack is sampled high at a
  // rising edge completes the access. Upstream holds its inputs while stall=1.

  state_t      state_q, state_d;
  logic        mem_op, aligned, accept, timeout;
  logic [4:0]  rd_q;
  logic        reg_write_q;

  assign mem_op  = valid_in && is_mem_op(alu_op);
  assign aligned = (alu_result[1:0] == 2'b00);
  assign accept  = (state_q == ST_IDLE) && mem_op && aligned;

  mem_timer #(.MAX(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  ((state_q == ST_WAIT) && !mem_ack),
    .expired (timeout)
  );

  assign stall = accept || ((state_q == ST_WAIT) && !mem_ack && !timeout);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (mem_ack || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      valid_out     <= 1'b0;
      wb_data       <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mem_req     <= 1'b1;
            mem_we      <= (alu_op == OP_SW);
            mem_addr    <= alu_result;
            mem_wdata   <= store_data;
            rd_q        <= rd_in;
            reg_write_q <= reg_write_in;
          end else if (valid_in) begin
            // Misaligned accesses retire immediately with no writeback.
            valid_out     <= 1'b1;
            wb_data       <= alu_result;
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in && !mem_op;
            misalign_err  <= mem_op;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req       <= 1'b0;
            valid_out     <= 1'b1;
            wb_data       <= mem_we ? mem_addr : mem_rdata;
            rd_out        <= rd_q;
            reg_write_out <= reg_write_q && !mem_we;
          end else if (timeout) begin
            mem_req       <= 1'b0;
            valid_out     <= 1'b1;
            wb_data       <= mem_addr;
            rd_out        <= rd_q;
            reg_write_out <= 1'b0;
            bus_err       <= 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_mem_access;

  localparam int T = 16;
  localparam int W = 38;
  localparam logic [5:0] LW_C = 6'b001000;
  localparam logic [5:0] SW_C = 6'b001010;

  logic        clk = 1'b0;
  logic        rst, valid_in, reg_write_in, mem_ack;
  logic [5:0]  alu_op;
  logic [31:0] alu_result, store_data, mem_rdata;
  logic [4:0]  rd_in;
  logic        stall, mem_req, mem_we, valid_out, reg_write_out, misalign_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [4:0]  rd_out;

  int n_pass = 0;
  int n_total = 0;
  int n_req, n_stall, n_cyc;

  // model state
  logic        model_ok = 1'b0;
  logic        m_busy, m_req, m_we, m_valid, m_rw, m_mis, m_berr;
  logic [31:0] m_addr, m_wdata, m_wb;
  logic [4:0]  m_rd, m_rd_out;
  logic        m_rw_cap;
  int          m_cnt;
  logic        c_memop, c_aligned, c_stall;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_item;

  mem_access #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op),
    .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .wb_data(wb_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: evaluated mid-cycle when inputs are stable, compares the
  // current outputs, then predicts the registered outputs after the next edge.
  always @(negedge clk) begin
    c_memop   = valid_in && (alu_op == LW_C || alu_op == SW_C);
    c_aligned = (alu_result[1:0] == 2'b00);
    c_stall   = (!m_busy && c_memop && c_aligned) || (m_busy && !mem_ack && m_cnt != T - 1);
    if (model_ok) begin
      chk("stall", stall, c_stall);
      chk("mem_req", mem_req, m_req);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("valid_out", valid_out, m_valid);
      chk("wb_data", wb_data, m_wb);
      chk("rd_out", rd_out, m_rd_out);
      chk("reg_write_out", reg_write_out, m_rw);
      chk("misalign_err", misalign_err, m_mis);
      chk("bus_err", bus_err, m_berr);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          sb_item = exp_q.pop_front();
          chk("wb_scoreboard", {rd_out, reg_write_out, wb_data}, sb_item);
        end
      end
    end
    m_valid = 1'b0; m_mis = 1'b0; m_berr = 1'b0;
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_rd = 0; m_rw_cap = 0; m_wb = 0; m_rd_out = 0; m_rw = 0;
      exp_q.delete();
      model_ok = 1'b1;
    end else if (!m_busy) begin
      if (c_memop && c_aligned) begin
        m_busy = 1; m_cnt = 0; m_req = 1; m_we = (alu_op == SW_C);
        m_addr = alu_result; m_wdata = store_data; m_rd = rd_in; m_rw_cap = reg_write_in;
      end else if (valid_in) begin
        m_valid = 1; m_wb = alu_result; m_rd_out = rd_in;
        m_rw = c_memop ? 1'b0 : reg_write_in;
        m_mis = c_memop;
      end
    end else if (mem_ack) begin
      m_busy = 0; m_req = 0; m_valid = 1; m_rd_out = m_rd;
      m_wb = m_we ? m_addr : mem_rdata;
      m_rw = m_we ? 1'b0 : m_rw_cap;
    end else if (m_cnt == T - 1) begin
      m_busy = 0; m_req = 0; m_valid = 1; m_berr = 1; m_rd_out = m_rd;
      m_wb = m_addr; m_rw = 0;
    end else begin
      m_cnt++;
    end
    if (m_valid && model_ok) exp_q.push_back({m_rd_out, m_rw, m_wb});
  end

  // Driver: called at posedge+2; presents one instruction, holds it while
  // stall is high, answers requests with ack in WAIT cycle ack_at (0 = never)
  // and optionally asserts rst in WAIT cycle rst_at. Returns at posedge+2.
  task automatic do_instr(input logic v, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic rw,
                          input int ack_at, input int rst_at, input logic [31:0] rdata,
                          input logic noise);
    int wcount;
    logic done;
    rst = 1'b0; valid_in = v; alu_op = op; alu_result = addr; store_data = data;
    rd_in = rd; reg_write_in = rw; mem_rdata = rdata;
    n_req = 0; n_stall = 0; n_cyc = 0; wcount = 0; done = 1'b0;
    while (!done && n_cyc < 40) begin
      if (mem_req) begin
        wcount++; n_req++;
        mem_ack = (wcount == ack_at);
        if (wcount == rst_at) rst = 1'b1;
      end else begin
        mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      if (stall) n_stall++;
      if (!stall || rst) done = 1'b1;
      n_cyc++;
      @(posedge clk); #2;
    end
    chk("instr_completes", done, 1);
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] addr;
    int sel, ack_at, rst_at;
    rst = 1'b1; valid_in = 0; alu_op = 0; alu_result = 0; store_data = 0;
    rd_in = 0; reg_write_in = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // ALU pass-through
    do_instr(1, 6'b100000, 32'h10, 0, 5, 1, 0, 0, 0, 0);
    chk("add_stall_cycles", n_stall, 0);
    chk("add_latency", n_cyc, 1);
    chk("add_valid", valid_out, 1);
    chk("add_wb", wb_data, 32'h10);
    chk("add_rd", rd_out, 5);
    chk("add_rw", reg_write_out, 1);

    // LW acked in the third WAIT cycle
    do_instr(1, LW_C, 32'h100, 0, 7, 1, 3, 0, 32'hDEADBEEF, 1);
    chk("lw_req_cycles", n_req, 3);
    chk("lw_stall_cycles", n_stall, 3);
    chk("lw_valid", valid_out, 1);
    chk("lw_wb", wb_data, 32'hDEADBEEF);
    chk("lw_rw", reg_write_out, 1);
    chk("lw_req_dropped", mem_req, 0);

    // SW acked in the first WAIT cycle
    do_instr(1, SW_C, 32'h204, 32'h12345678, 3, 1, 1, 0, 32'hAAAA5555, 0);
    chk("sw_latency", n_cyc, 2);
    chk("sw_we", mem_we, 1);
    chk("sw_wdata", mem_wdata, 32'h12345678);
    chk("sw_addr", mem_addr, 32'h204);
    chk("sw_rw", reg_write_out, 0);
    chk("sw_wb", wb_data, 32'h204);

    // misaligned LW
    do_instr(1, LW_C, 32'h102, 0, 9, 1, 1, 0, 0, 0);
    chk("mis_err", misalign_err, 1);
    chk("mis_req_cycles", n_req, 0);
    chk("mis_stall_cycles", n_stall, 0);
    chk("mis_valid", valid_out, 1);
    chk("mis_rw", reg_write_out, 0);
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mis_pulse_end", misalign_err, 0);
    chk("bubble_valid", valid_out, 0);

    // timeout, then ack exactly on the last allowed WAIT cycle
    do_instr(1, LW_C, 32'h300, 0, 4, 1, 0, 0, 32'h1, 0);
    chk("to_req_cycles", n_req, 16);
    chk("to_bus_err", bus_err, 1);
    chk("to_req_low", mem_req, 0);
    chk("to_rw", reg_write_out, 0);
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_pulse_end", bus_err, 0);
    do_instr(1, LW_C, 32'h304, 0, 4, 1, 16, 0, 32'h0BADF00D, 0);
    chk("ack16_req_cycles", n_req, 16);
    chk("ack16_no_bus_err", bus_err, 0);
    chk("ack16_wb", wb_data, 32'h0BADF00D);
    chk("ack16_rw", reg_write_out, 1);

    // reset in the second WAIT cycle, ack arriving one cycle late
    do_instr(1, LW_C, 32'h400, 0, 6, 1, 0, 2, 32'h5, 0);
    chk("rstw_req_low", mem_req, 0);
    chk("rstw_valid", valid_out, 0);
    rst = 1'b0; valid_in = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    chk("late_ack_valid", valid_out, 0);
    chk("late_ack_rw", reg_write_out, 0);
    chk("late_ack_req", mem_req, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; valid_in = 1'b1; alu_op = LW_C; alu_result = 32'h40;
        mem_ack = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; mem_ack = 1'b0;
      end
      sel = $urandom_range(0, 2);
      if (sel == 0) op = LW_C;
      else if (sel == 1) op = SW_C;
      else begin
        op = 6'($urandom_range(0, 63));
        if (op == LW_C || op == SW_C) op = 6'b000000;
      end
      addr = $urandom;
      addr[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ack_at = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 18);
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 4) : 0;
      do_instr($urandom_range(0, 4) != 0, op, addr, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), ack_at, rst_at, $urandom, 1'($urandom_range(0, 1)));
    end

    rst = 1'b0; valid_in = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
